// File: rtl/execute_memory_pipe_if.sv
// Bundle between the execute stage and the EX/MEM pipeline register:
// stage controls, the ex_* fields, and the registered mem_* and side outputs.
// The master modport drives the ex_* fields; the pipe register uses the slave modport.
interface execute_memory_pipe_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 32
);
   logic                    stall;
   logic                    flush;
   logic                    ex_valid;
   logic [DATA_WIDTH-1:0]   ex_ALU_result;
   logic [DATA_WIDTH-1:0]   ex_store_data;
   logic [4:0]              ex_rd;
   logic                    ex_reg_write;
   logic                    ex_mem_read;
   logic                    ex_mem_write;
   logic [1:0]              ex_mem_size;
   logic                    ex_branch;
   logic                    ex_jump;
   logic [ADDRESS_BITS-1:0] ex_target;

   logic                    mem_valid;
   logic [DATA_WIDTH-1:0]   mem_ALU_result;
   logic [DATA_WIDTH-1:0]   mem_store_data;
   logic [4:0]              mem_rd;
   logic                    mem_reg_write;
   logic                    mem_mem_read;
   logic                    mem_mem_write;
   logic [1:0]              mem_mem_size;
   logic                    redirect;
   logic [ADDRESS_BITS-1:0] redirect_PC;
   logic                    forward_valid;
   logic [DATA_WIDTH-1:0]   forward_data;
   logic                    load_hazard;
   logic                    misaligned;

   modport master (
      output stall, flush, ex_valid, ex_ALU_result, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
             ex_branch, ex_jump, ex_target,
      input  mem_valid, mem_ALU_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_mem_size, redirect, redirect_PC,
             forward_valid, forward_data, load_hazard, misaligned
   );

   modport slave (
      input  stall, flush, ex_valid, ex_ALU_result, ex_store_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
             ex_branch, ex_jump, ex_target,
      output mem_valid, mem_ALU_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_mem_size, redirect, redirect_PC,
             forward_valid, forward_data, load_hazard, misaligned
   );
endinterface

// File: rtl/execute_memory_pipe.sv
// EX/MEM pipeline register with stall/flush, branch redirect and wrong-path squash,
// plus forwarding and load-use hazard flags derived from the registered entry.
// Optional macro MISALIGN_CHECK_EN compiles in the load/store alignment check.
module execute_memory_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   execute_memory_pipe_if.slave bus
);
   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic                    capture;
   logic                    live;
   logic                    taken;
   logic                    mis;

   logic                    valid_q;
   logic [DATA_WIDTH-1:0]   alu_q;
   logic [DATA_WIDTH-1:0]   store_q;
   logic [4:0]              rd_q;
   logic                    reg_write_q;
   logic                    mem_read_q;
   logic                    mem_write_q;
   logic [1:0]              size_q;
   logic                    redirect_q;
   logic [ADDRESS_BITS-1:0] redirect_pc_q;
   logic                    misaligned_q;

   // An edge captures only when neither stall nor flush is active.
   assign capture = ~bus.stall & ~bus.flush;
   // The entry right after a taken branch/jump is wrong-path and enters as a bubble.
   assign live    = bus.ex_valid & (state_q == RUN);
   assign taken   = live & (bus.ex_jump | (bus.ex_branch & bus.ex_ALU_result[0]));

`ifdef MISALIGN_CHECK_EN
   assign mis = live & (bus.ex_mem_read | bus.ex_mem_write) &
                (((bus.ex_mem_size == 2'd1) & bus.ex_ALU_result[0]) |
                 ((bus.ex_mem_size == 2'd2) & (bus.ex_ALU_result[1:0] != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   // Squash tracking state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Next state: arm squash on a taken capture, leave it on the next capture or a flush.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (capture && taken)        state_d = SQUASH;
         SQUASH:  if (bus.flush || capture)    state_d = RUN;
         default:                              state_d = RUN;
      endcase
   end

   // Pipeline register: reset clears all, flush makes a bubble, stall holds, else capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q       <= 1'b0;
         alu_q         <= '0;
         store_q       <= '0;
         rd_q          <= '0;
         reg_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         size_q        <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         misaligned_q  <= 1'b0;
      end else if (bus.flush) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         misaligned_q <= 1'b0;
         redirect_q   <= 1'b0;
      end else if (bus.stall) begin
         redirect_q <= 1'b0;
      end else begin
         valid_q      <= live;
         alu_q        <= bus.ex_ALU_result;
         store_q      <= bus.ex_store_data;
         rd_q         <= bus.ex_rd;
         reg_write_q  <= bus.ex_reg_write & live & ~mis;
         mem_read_q   <= bus.ex_mem_read  & live & ~mis;
         mem_write_q  <= bus.ex_mem_write & live & ~mis;
         size_q       <= bus.ex_mem_size;
         misaligned_q <= mis;
         redirect_q   <= taken;
         if (taken) redirect_pc_q <= bus.ex_target;
      end
   end

   assign bus.mem_valid      = valid_q;
   assign bus.mem_ALU_result = alu_q;
   assign bus.mem_store_data = store_q;
   assign bus.mem_rd         = rd_q;
   assign bus.mem_reg_write  = reg_write_q;
   assign bus.mem_mem_read   = mem_read_q;
   assign bus.mem_mem_write  = mem_write_q;
   assign bus.mem_mem_size   = size_q;
   assign bus.redirect       = redirect_q;
   assign bus.redirect_PC    = redirect_pc_q;
   assign bus.misaligned     = misaligned_q;
   assign bus.forward_valid  = valid_q & reg_write_q & ~mem_read_q & (rd_q != 5'd0);
   assign bus.forward_data   = alu_q;
   assign bus.load_hazard    = valid_q & mem_read_q & reg_write_q & (rd_q != 5'd0);
endmodule

// File: tb/tb_execute_memory_pipe.sv
// Directed bench for execute_memory_pipe: a per-edge behavioural model of the EX/MEM
// register checked every negedge, plus literal expectations for the key scenarios.
module tb_execute_memory_pipe;
   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   execute_memory_pipe_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) bus ();

   execute_memory_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          valid;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      bit          rw, mr, mw;
      logic [1:0]  size;
      bit          redirect;
      logic [31:0] rpc;
      bit          mis;
   } entry_t;

   entry_t m;
   bit     squash_next;   // next accepted entry is on the wrong path
   bit     model_ok = 0;

`ifdef MISALIGN_CHECK_EN
   localparam bit CHECK_ON = 1'b1;
`else
   localparam bit CHECK_ON = 1'b0;
`endif

   always @(posedge clock) begin
      bit live, t, bad_align;
      model_ok = 1;
      if (reset) begin
         m = '{default: 0};
         squash_next = 0;
      end else if (bus.flush) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mis = 0; m.redirect = 0;
         squash_next = 0;
      end else if (bus.stall) begin
         m.redirect = 0;
      end else begin
         live = bus.ex_valid && !squash_next;
         t = live && (bus.ex_jump || (bus.ex_branch && bus.ex_ALU_result[0]));
         bad_align = (bus.ex_mem_size == 2'd1 && bus.ex_ALU_result % 2 != 0) ||
                     (bus.ex_mem_size == 2'd2 && bus.ex_ALU_result % 4 != 0);
         m.mis   = CHECK_ON && live && (bus.ex_mem_read || bus.ex_mem_write) && bad_align;
         m.valid = live;
         m.alu   = bus.ex_ALU_result;
         m.sd    = bus.ex_store_data;
         m.rd    = bus.ex_rd;
         m.size  = bus.ex_mem_size;
         m.rw    = live && !m.mis && bus.ex_reg_write;
         m.mr    = live && !m.mis && bus.ex_mem_read;
         m.mw    = live && !m.mis && bus.ex_mem_write;
         m.redirect = t;
         if (t) m.rpc = bus.ex_target;
         squash_next = t;
      end
   end

   // Compare every cycle on the falling edge; payload only matters for valid entries.
   always @(negedge clock) begin
      if (model_ok) begin
         chk("m_valid",    bus.mem_valid,     m.valid);
         chk("m_rw",       bus.mem_reg_write, m.rw);
         chk("m_mr",       bus.mem_mem_read,  m.mr);
         chk("m_mw",       bus.mem_mem_write, m.mw);
         chk("m_redirect", bus.redirect,      m.redirect);
         chk("m_rpc",      bus.redirect_PC,   m.rpc);
         chk("m_mis",      bus.misaligned,    m.mis);
         chk("m_fwd_v",    bus.forward_valid, m.valid && m.rw && !m.mr && m.rd != 0);
         chk("m_ld_haz",   bus.load_hazard,   m.valid && m.mr && m.rw && m.rd != 0);
         if (m.valid) begin
            chk("m_alu",  bus.mem_ALU_result, m.alu);
            chk("m_sd",   bus.mem_store_data, m.sd);
            chk("m_rd",   bus.mem_rd,         m.rd);
            chk("m_size", bus.mem_mem_size,   m.size);
            chk("m_fwd_d", bus.forward_data,  m.alu);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                        input logic [1:0] size, input bit br, input bit jp,
                        input logic [31:0] tgt);
      bus.ex_valid = v;  bus.ex_ALU_result = alu; bus.ex_store_data = sd;
      bus.ex_rd = rd;    bus.ex_reg_write = rw;   bus.ex_mem_read = mr;
      bus.ex_mem_write = mw; bus.ex_mem_size = size;
      bus.ex_branch = br; bus.ex_jump = jp; bus.ex_target = tgt;
   endtask

   initial begin
      reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
      drive(1, 32'hFFFF_FFFF, 32'hAAAA_5555, 5'd9, 1, 0, 0, 2'd2, 0, 1, 32'h0000_0F00);
      tick(); tick();
      chk("rst_valid",    bus.mem_valid, 1'b0);
      chk("rst_alu",      bus.mem_ALU_result, 32'h0);
      chk("rst_redirect", bus.redirect, 1'b0);
      chk("rst_rpc",      bus.redirect_PC, 32'h0);
      chk("rst_mis",      bus.misaligned, 1'b0);
      reset = 1'b0;

      // simple ALU result forwarded
      drive(1, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("fwd_alu",   bus.mem_ALU_result, 32'h1234);
      chk("fwd_valid", bus.forward_valid, 1'b1);
      chk("fwd_data",  bus.forward_data, 32'h1234);

      // taken branch, wrong-path entry squashed, following entry normal
      drive(1, 32'h1, 32'h0, 5'd0, 0, 0, 0, 2'd2, 1, 0, 32'h0000_0080);
      tick();
      chk("br_redirect", bus.redirect, 1'b1);
      chk("br_rpc",      bus.redirect_PC, 32'h80);
      drive(1, 32'h55, 32'h0, 5'd3, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("br_pulse_end", bus.redirect, 1'b0);
      chk("wp_valid",     bus.mem_valid, 1'b0);
      chk("wp_fwd",       bus.forward_valid, 1'b0);
      drive(1, 32'h77, 32'h0, 5'd4, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("after_wp_valid", bus.mem_valid, 1'b1);
      chk("after_wp_alu",   bus.mem_ALU_result, 32'h77);

      // not-taken branch (ALU bit0 = 0): no redirect
      drive(1, 32'h2, 32'h0, 5'd0, 0, 0, 0, 2'd2, 1, 0, 32'h0000_0100);
      tick();
      chk("nt_redirect", bus.redirect, 1'b0);

      // load then stall for 3 cycles
      drive(1, 32'h200, 32'h0, 5'd7, 1, 1, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("ld_hazard", bus.load_hazard, 1'b1);
      bus.stall = 1'b1;
      drive(1, 32'hBEEF, 32'h1, 5'd1, 1, 0, 0, 2'd0, 0, 1, 32'h44);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stl_alu", bus.mem_ALU_result, 32'h200);
         chk("stl_rd",  bus.mem_rd, 5'd7);
         chk("stl_haz", bus.load_hazard, 1'b1);
         chk("stl_fwd", bus.forward_valid, 1'b0);
      end
      bus.stall = 1'b0;

      // store, then flush together with stall
      drive(1, 32'h300, 32'hDEAD, 5'd0, 0, 0, 1, 2'd2, 0, 0, 32'h0);
      tick();
      chk("st_mw", bus.mem_mem_write, 1'b1);
      bus.stall = 1'b1; bus.flush = 1'b1;
      tick();
      chk("fl_valid", bus.mem_valid, 1'b0);
      chk("fl_mw",    bus.mem_mem_write, 1'b0);
      bus.stall = 1'b0; bus.flush = 1'b0;

      // taken branch, redirect during stall stays one cycle, squash survives the stall
      drive(1, 32'h1, 32'h0, 5'd0, 0, 0, 0, 2'd2, 1, 0, 32'h0000_0C00);
      tick();
      chk("br2_redirect", bus.redirect, 1'b1);
      bus.stall = 1'b1;
      drive(1, 32'h66, 32'h0, 5'd6, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("br2_stall_pulse", bus.redirect, 1'b0);
      bus.stall = 1'b0;
      tick();
      chk("br2_wp_valid", bus.mem_valid, 1'b0);

      // jump, then reset while squashing
      drive(1, 32'h0, 32'h0, 5'd1, 1, 0, 0, 2'd2, 0, 1, 32'h0000_0040);
      tick();
      chk("jmp_redirect", bus.redirect, 1'b1);
      reset = 1'b1;
      drive(1, 32'h88, 32'h0, 5'd2, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("sqrst_valid",    bus.mem_valid, 1'b0);
      chk("sqrst_redirect", bus.redirect, 1'b0);
      chk("sqrst_rpc",      bus.redirect_PC, 32'h0);
      reset = 1'b0;
      drive(1, 32'h99, 32'h0, 5'd2, 1, 0, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("post_rst_valid", bus.mem_valid, 1'b1);
      chk("post_rst_alu",   bus.mem_ALU_result, 32'h99);

      // word load at 0x102
      drive(1, 32'h0000_0102, 32'h0, 5'd8, 1, 1, 0, 2'd2, 0, 0, 32'h0);
      tick();
      chk("mis_valid", bus.mem_valid, 1'b1);
`ifdef MISALIGN_CHECK_EN
      chk("mis_flag", bus.misaligned, 1'b1);
      chk("mis_mr",   bus.mem_mem_read, 1'b0);
`else
      chk("mis_flag", bus.misaligned, 1'b0);
      chk("mis_mr",   bus.mem_mem_read, 1'b1);
`endif
      // aligned halfword load passes either way
      drive(1, 32'h0000_0102, 32'h0, 5'd8, 1, 1, 0, 2'd1, 0, 0, 32'h0);
      tick();
      chk("half_ok_mis", bus.misaligned, 1'b0);
      chk("half_ok_mr",  bus.mem_mem_read, 1'b1);

      drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 2'd0, 0, 0, 32'h0);
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/execute_memory_pipe.md
EXECUTE_MEMORY_PIPE -- requirements
Module: execute_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of ALU result and store data.
REQ-002 SHALL have parameter ADDRESS_BITS, default 32: width of PC and branch target.
REQ-003 SHALL have ports: clock in 1 (sole clock); reset in 1 (synchronous, active-high).
REQ-004 SHALL have ports: stall in 1 (hold contents); flush in 1 (insert bubble).
REQ-005 SHALL have ports: ex_valid in 1; ex_ALU_result in DATA_WIDTH; ex_store_data in DATA_WIDTH; ex_rd in 5.
REQ-006 SHALL have ports: ex_reg_write, ex_mem_read, ex_mem_write in 1 each; ex_mem_size in 2 (0 byte, 1 half, 2 word).
REQ-007 SHALL have ports: ex_branch in 1 (conditional branch); ex_jump in 1 (JAL/JALR); ex_target in ADDRESS_BITS.
REQ-008 SHALL have outputs: mem_valid 1, mem_ALU_result DATA_WIDTH, mem_store_data DATA_WIDTH, mem_rd 5, mem_reg_write 1, mem_mem_read 1, mem_mem_write 1, mem_mem_size 2.
REQ-009 SHALL have outputs: redirect 1, redirect_PC ADDRESS_BITS, forward_valid 1, forward_data DATA_WIDTH, load_hazard 1, misaligned 1.

Function
REQ-010 SHALL capture all ex_* fields into mem_* registers on a rising clock edge when neither stall nor flush is high.
REQ-011 SHALL hold every mem_* register unchanged on an edge where stall is high and flush is low.
REQ-012 SHALL clear mem_valid, mem_reg_write, mem_mem_read and mem_mem_write on an edge where flush is high, regardless of stall; data fields are don't-care.
REQ-013 SHALL force captured mem_reg_write, mem_mem_read and mem_mem_write to 0 whenever the captured ex_valid is 0.
REQ-014 SHALL compute taken = ex_valid & (ex_jump | (ex_branch & ex_ALU_result[0])) at capture.
REQ-015 SHALL assert redirect for exactly one cycle, the cycle after a capture with taken=1, with redirect_PC = captured ex_target.
REQ-016 SHALL keep the redirect pulse one cycle long even if stall is high during it; flush on that edge does not cancel a pulse already asserted.
REQ-017 SHALL implement a two-state FSM, RUN and SQUASH; reset enters RUN.
REQ-018 SHALL go RUN->SQUASH on a capture with taken=1; in SQUASH, the next capturing edge stores the wrong-path entry as a bubble (valid 0) and returns to RUN.
REQ-019 SHALL remain in SQUASH across stalled edges; flush in SQUASH returns the FSM to RUN.
REQ-020 SHALL drive forward_valid = mem_valid & mem_reg_write & ~mem_mem_read & (mem_rd != 0), forward_data = mem_ALU_result, combinationally.
REQ-021 SHALL drive load_hazard = mem_valid & mem_mem_read & mem_reg_write & (mem_rd != 0), combinationally.
REQ-022 SHALL have zero combinational path from any ex_* input to any output; latency is one cycle.

Reset
REQ-023 SHALL, on reset, set all mem_* outputs, redirect, redirect_PC and misaligned to 0, and the FSM to RUN.
REQ-024 SHALL give reset priority over flush and stall, and discard any pending squash.

Configuration
REQ-025 SHALL use macro MISALIGN_CHECK_EN to compile the alignment check in or out.
REQ-026 SHALL, with MISALIGN_CHECK_EN defined, flag a capture as misaligned when ex_mem_read or ex_mem_write is set and (size 1 and ALU_result[0]!=0) or (size 2 and ALU_result[1:0]!=0).
REQ-027 SHALL, on a misaligned capture, set misaligned=1 and clear mem_mem_read, mem_mem_write and mem_reg_write, keeping mem_valid=1; misaligned follows the same stall/flush/reset rules as mem_* registers.
REQ-028 SHALL, without MISALIGN_CHECK_EN, tie misaligned to 0 and pass all accesses unchanged.

Verification
REQ-029 SHALL test: capture of ALU_result 0x0000_1234, rd 5, reg_write 1 -> next cycle mem_ALU_result 0x1234, forward_valid 1, forward_data 0x1234.
REQ-030 SHALL test: branch with ALU_result 1, target 0x0000_0080 -> redirect high one cycle with redirect_PC 0x80; following ex entry lands with mem_valid 0.
REQ-031 SHALL test: stall held 3 cycles after a load to rd 7 -> mem_* unchanged for 3 cycles, load_hazard 1, forward_valid 0.
REQ-032 SHALL test: flush and stall together while holding valid store -> next cycle mem_valid 0, mem_mem_write 0.
REQ-033 SHALL test: reset asserted in SQUASH state -> all outputs 0; next valid entry captured normally with mem_valid 1.
REQ-034 SHALL test, with MISALIGN_CHECK_EN: word load at address 0x0000_0102 -> misaligned 1, mem_mem_read 0; without macro -> misaligned 0, mem_mem_read 1.
